gg_mb_parse_sequencer: RTL and testbench
========================================

// Module: gg_mb_parse_sequencer
// PURPOSE
//  Slice-level controller for gg_parse_lattice_macroblock: buffers WID-bit bitstream words
//  from an upstream valid/ready stream and presents each word with its 32-bit lookahead pad.
//  Injects mb_start for the slice's first macroblock, stalls the lattice on underflow, and
//  counts mb_end pulses to a programmed macroblock count. Flags underrun/timeout, flushes
//  to s_last. Sits between the bitstream word source and the lattice pair (MB + transform block).
// PARAMETERS
//  WID            32   word width in bits; must be >= 32 so one lookahead word covers pad
//  TIMEOUT_WORDS  128  max consecutive lattice steps with no mb_end (PCM MB = 3072/WID + 1)
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high
//  start          in   1       pulse: begin slice (accepted only in IDLE)
//  num_mb         in   16      MBs in slice, sampled on start; 0 treated as 1
//  busy           out  1       high in any state other than IDLE
//  done           out  1       1-cycle pulse on return to IDLE
//  err_underrun   out  1       s_last consumed before num_mb MBs ended; held until next start
//  err_timeout    out  1       TIMEOUT_WORDS steps with no mb_end; held until next start
//  mb_count       out  16      MBs completed in current/last slice
//  s_data         in   WID     bitstream word, first bit at MSB
//  s_valid        in   1       s_data valid
//  s_last         in   1       final word of slice
//  s_ready        out  1       word accepted when s_valid & s_ready
//  lat_reset      out  1       lattice flop clear; high in IDLE and FLUSH
//  lat_en         out  1       lattice step: word on lat_bits consumed this cycle
//  lat_bits       out  WID     current word
//  lat_pad        out  32      next word [WID-1 -: 32], or 0 when current word is last
//  lat_mb_start   out  WID     one-hot MB start; 1<<(WID-1) on first step of slice, else 0
//  lat_mb_end     in   WID     lattice MB end flags, valid same cycle as lat_en
// BEHAVIOUR
//  Reset: state IDLE; buffers empty; all outputs 0 except lat_reset=1; mb_count=0; errors 0.
//  Buffer: 2 entries CUR, NXT (each data, last, valid); words fill CUR then NXT, NXT moves to CUR
//    on step. s_ready = in FILL/RUN/FLUSH and (!NXT.v or step). Never drops or duplicates words.
//  States:
//   IDLE : start -> FILL; latch num_mb into rem; clear mb_count, errors, first=1, tcnt=0.
//   FILL : accept words; -> RUN once CUR.v and (NXT.v or CUR.last).
//   RUN  : step = CUR.v & (NXT.v | CUR.last); lat_en = step; lat_bits/lat_pad/lat_mb_start are
//          0 when !step (lattice holds state). On step: first<=0; k = popcount(lat_mb_end),
//          clipped to rem; rem-=k; mb_count+=k; tcnt = k ? 0 : tcnt+1.
//          rem hits 0 -> FLUSH (normal). CUR.last stepped with rem>0 -> err_underrun, IDLE.
//          tcnt reaches TIMEOUT_WORDS -> err_timeout, FLUSH.
//   FLUSH: lat_reset=1; discard buffered and incoming words until a word with last is consumed
//          (including already buffered one) -> IDLE. Entering IDLE drives done=1 for 1 cycle.
//  mb_end bits beyond the final MB in the completing word are ignored (clip).
//  Simultaneous rem->0 and CUR.last on same step: normal completion, no error, straight to IDLE.
//  Simultaneous timeout and mb_end on same step: mb_end wins (tcnt clears).
//  start outside IDLE ignored. reset mid-slice: immediate IDLE, buffers emptied, no done pulse.
//  Latency: first lat_en no earlier than 1 cycle after 2nd word (or last word) accepted.
//  Widths: popcount over WID bits, saturating add not needed (clip keeps mb_count <= num_mb).
// TESTING (bench uses a lattice stub emitting lat_mb_end at scripted positions)
//  num_mb=1, 4 words, stub mb_end bit 6 of word 3, s_last on word 3 -> 4 lat_en, mb_count=1,
//    done, no errors; lat_mb_start=0x80000000 only on 1st step; pad of word 3 = 0.
//  num_mb=3, 2 words, stub mb_end bits {20,5} in word0, {28} in word1 -> mb_count=3, done.
//  num_mb=2, mb_end bits {20,10,2} in one word -> mb_count=2 (third clipped), then FLUSH drains
//    5 extra words to s_last; s_ready high throughout flush.
//  s_valid gaps of 3 cycles between words -> lat_en low during gaps, lat_bits/pad stable-zero,
//    step count still 4, result identical to case 1.
//  num_mb=2, s_last after 1 mb_end -> err_underrun=1, mb_count=1, done pulse.
//  TIMEOUT_WORDS=4, no mb_end for 4 steps -> err_timeout, FLUSH to s_last; reset asserted mid-RUN
//    -> busy=0 next cycle, no done pulse.

Source files
------------

// File: rtl/gg_mb_parse_sequencer_if.sv
// Bitstream word stream between the word source and the MB parse sequencer.
// Ports: s_data (first bit at MSB), s_valid, s_last, s_ready; master = source.
interface gg_mb_parse_sequencer_if #(
   parameter int WID = 32
);
   logic [WID-1:0] s_data;
   logic           s_valid;
   logic           s_last;
   logic           s_ready;

   modport master (
      output s_data, s_valid, s_last,
      input  s_ready
   );

   modport slave (
      input  s_data, s_valid, s_last,
      output s_ready
   );
endinterface

// File: rtl/gg_mb_parse_sequencer.sv
// Slice controller for the MB parse lattice: 2-word buffer, lookahead pad,
// mb_start injection, mb_end counting, underrun/timeout flags, flush to s_last.
// Ports: clk/reset, start/num_mb control, busy/done/err_*/mb_count status,
//   s (word stream slave), lat_* lattice drive, lat_mb_end lattice feedback.
module gg_mb_parse_sequencer #(
   parameter int WID           = 32,
   parameter int TIMEOUT_WORDS = 128
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [15:0]            num_mb,
   output logic                   busy,
   output logic                   done,
   output logic                   err_underrun,
   output logic                   err_timeout,
   output logic [15:0]            mb_count,
   gg_mb_parse_sequencer_if.slave s,
   output logic                   lat_reset,
   output logic                   lat_en,
   output logic [WID-1:0]         lat_bits,
   output logic [31:0]            lat_pad,
   output logic [WID-1:0]         lat_mb_start,
   input  logic [WID-1:0]         lat_mb_end
);

   localparam int TW_W = $clog2(TIMEOUT_WORDS + 1);
   localparam int KW   = $clog2(WID + 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t          state, state_n;
   logic [WID-1:0]  cur_d, nxt_d;
   logic            cur_l, nxt_l, cur_v, nxt_v;
   logic [15:0]     rem;
   logic            first;
   logic [TW_W-1:0] tcnt, tcnt_n;
   logic [KW-1:0]   k_raw;
   logic [15:0]     k;
   logic            step, pop, acc, last_held;
   logic            set_under, set_tmo;

   always_comb begin
      k_raw = '0;
      for (int i = 0; i < WID; i++)
         k_raw = k_raw + KW'(lat_mb_end[i]);
   end

   // mb_end flags past the slice's final MB are clipped away
   assign k      = (16'(k_raw) > rem) ? rem : 16'(k_raw);
   assign tcnt_n = (k != 16'd0) ? '0 : tcnt + 1'b1;

   assign step = (state == RUN) & cur_v & (nxt_v | cur_l);
   // FLUSH discards one buffered word per cycle
   assign pop  = step | ((state == FLUSH) & cur_v);

   // Once the slice's last word is buffered, words after it belong
   // to the next slice and must stay upstream.
   assign last_held = (cur_v & cur_l) | (nxt_v & nxt_l);
   assign s.s_ready = (state != IDLE) & ~last_held & (~nxt_v | pop);
   assign acc       = s.s_valid & s.s_ready;

   always_comb begin
      state_n   = state;
      set_under = 1'b0;
      set_tmo   = 1'b0;
      unique case (state)
         IDLE:  if (start) state_n = FILL;
         FILL:  if (cur_v & (nxt_v | cur_l)) state_n = RUN;
         RUN: begin
            if (step) begin
               if (rem == k) begin
                  state_n = cur_l ? IDLE : FLUSH;
               end else if (cur_l) begin
                  set_under = 1'b1;
                  state_n   = IDLE;
               end else if (tcnt_n == TW_W'(TIMEOUT_WORDS)) begin
                  set_tmo = 1'b1;
                  state_n = FLUSH;
               end
            end
         end
         FLUSH: if (pop & cur_l) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy         = (state != IDLE);
   assign lat_reset    = (state == IDLE) | (state == FLUSH);
   assign lat_en       = step;
   assign lat_bits     = step ? cur_d : '0;
   assign lat_pad      = (step & ~cur_l) ? nxt_d[WID-1 -: 32] : 32'd0;
   assign lat_mb_start = (step & first) ? {1'b1, {(WID-1){1'b0}}} : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cur_v        <= 1'b0;
         nxt_v        <= 1'b0;
         rem          <= '0;
         first        <= 1'b0;
         tcnt         <= '0;
         mb_count     <= '0;
         err_underrun <= 1'b0;
         err_timeout  <= 1'b0;
         done         <= 1'b0;
      end else begin
         state <= state_n;
         done  <= (state != IDLE) & (state_n == IDLE);
         if ((state == IDLE) & start) begin
            rem          <= (num_mb == 16'd0) ? 16'd1 : num_mb;
            mb_count     <= '0;
            err_underrun <= 1'b0;
            err_timeout  <= 1'b0;
            first        <= 1'b1;
            tcnt         <= '0;
         end
         if (step) begin
            first    <= 1'b0;
            rem      <= rem - k;
            mb_count <= mb_count + k;
            tcnt     <= tcnt_n;
         end
         if (set_under) err_underrun <= 1'b1;
         if (set_tmo)   err_timeout  <= 1'b1;
         if (pop) begin
            cur_d <= nxt_d;
            cur_l <= nxt_l;
            cur_v <= nxt_v;
            nxt_v <= 1'b0;
            if (acc) begin
               if (nxt_v) begin
                  nxt_d <= s.s_data;
                  nxt_l <= s.s_last;
                  nxt_v <= 1'b1;
               end else begin
                  cur_d <= s.s_data;
                  cur_l <= s.s_last;
                  cur_v <= 1'b1;
               end
            end
         end else if (acc) begin
            if (cur_v) begin
               nxt_d <= s.s_data;
               nxt_l <= s.s_last;
               nxt_v <= 1'b1;
            end else begin
               cur_d <= s.s_data;
               cur_l <= s.s_last;
               cur_v <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_gg_mb_parse_sequencer.sv
// Self-checking bench for gg_mb_parse_sequencer with a scripted lattice stub.
// Scoreboard of expected lattice words; slice results checked after done.
module tb_gg_mb_parse_sequencer;
   localparam int WID = 32;
   localparam int TW  = 4;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [15:0] num_mb;
   logic        busy, done, err_u, err_t;
   logic [15:0] mb_count;
   logic        lat_reset, lat_en;
   logic [31:0] lat_bits, lat_pad, lat_mb_start, lat_mb_end;

   gg_mb_parse_sequencer_if #(.WID(WID)) sif ();

   gg_mb_parse_sequencer #(.WID(WID), .TIMEOUT_WORDS(TW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .num_mb       (num_mb),
      .busy         (busy),
      .done         (done),
      .err_underrun (err_u),
      .err_timeout  (err_t),
      .mb_count     (mb_count),
      .s            (sif.slave),
      .lat_reset    (lat_reset),
      .lat_en       (lat_en),
      .lat_bits     (lat_bits),
      .lat_pad      (lat_pad),
      .lat_mb_start (lat_mb_start),
      .lat_mb_end   (lat_mb_end)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] bits;
      logic [31:0] pad;
      logic [31:0] mbs;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] words[16];
   logic [31:0] script[16];
   int          step_idx = 0;
   int          base = 0;
   int          n_steps = 0;
   int          done_cnt = 0;
   bit          zero_chk = 0;
   bit          sb_en = 1;

   // lattice stub: scripted mb_end per step of the current slice
   assign lat_mb_end = lat_en ? script[4'(step_idx - base)] : 32'd0;

   always @(posedge clk)
      if (lat_en) step_idx <= step_idx + 1;

   always @(negedge clk) begin
      exp_t e;
      #1;
      if (lat_en) begin
         n_steps++;
         if (sb_en) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected_step", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("lat_bits", lat_bits, e.bits);
               chk("lat_pad", lat_pad, e.pad);
               chk("lat_mb_start", lat_mb_start, e.mbs);
            end
         end
      end else if (zero_chk && busy) begin
         chk("hold_bits", lat_bits, 0);
         chk("hold_pad", lat_pad, 0);
         chk("hold_mbs", lat_mb_start, 0);
      end
      if (done) done_cnt++;
   end

   task automatic send_words(input int n, input int gap,
                             input bit use_last, output int stalls);
      int st0 = n_steps;
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         sif.s_valid = 1'b0;
         repeat (gap) @(negedge clk);
         sif.s_valid = 1'b1;
         sif.s_data  = words[i];
         sif.s_last  = use_last && (i == n - 1);
         for (int t = 0; ; t++) begin
            #1;
            if (sif.s_ready) break;
            if (n_steps > st0) stalls++;
            if (t > 100) begin
               chk("drv_timeout", 1, 0);
               sif.s_valid = 1'b0;
               return;
            end
            @(negedge clk);
         end
         @(negedge clk);
      end
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
   endtask

   task automatic run_case(input string name, input int n, input int nm,
                           input int gap, input bit stall_chk);
      int          rem, cnt, tcnt, k, st0, d0, stalls, exp_steps;
      bit          e_u, e_t;
      exp_t        e;
      rem = (nm == 0) ? 1 : nm;
      cnt = 0; tcnt = 0; exp_steps = 0; e_u = 0; e_t = 0;
      for (int i = 0; i < n; i++) words[i] = $urandom;
      for (int i = 0; i < n; i++) begin
         e.bits = words[i];
         e.pad  = (i == n - 1) ? 32'd0 : words[i+1];
         e.mbs  = (i == 0) ? 32'h8000_0000 : 32'd0;
         sbq.push_back(e);
         exp_steps++;
         k = $countones(script[i]);
         if (k > rem) k = rem;
         rem -= k; cnt += k;
         tcnt = (k != 0) ? 0 : tcnt + 1;
         if (rem == 0) break;
         if (i == n - 1) begin e_u = 1; break; end
         if (tcnt == TW) begin e_t = 1; break; end
      end
      base = step_idx; st0 = n_steps; d0 = done_cnt;
      zero_chk = (gap > 0);
      @(negedge clk);
      start = 1'b1; num_mb = 16'(nm);
      @(negedge clk);
      start = 1'b0;
      send_words(n, gap, 1'b1, stalls);
      for (int t = 0; t < 200 && done_cnt == d0; t++) begin
         @(negedge clk); #2;
      end
      repeat (3) @(negedge clk);
      zero_chk = 0;
      chk({name, "_done"}, done_cnt - d0, 1);
      chk({name, "_steps"}, n_steps - st0, exp_steps);
      chk({name, "_mb_count"}, mb_count, cnt);
      chk({name, "_underrun"}, err_u, e_u);
      chk({name, "_timeout"}, err_t, e_t);
      chk({name, "_sb_empty"}, sbq.size(), 0);
      chk({name, "_busy"}, busy, 0);
      if (stall_chk) chk({name, "_flush_stalls"}, stalls, 0);
      sbq.delete();
   endtask

   initial begin
      int st0, d0, stalls;
      reset = 1'b1; start = 1'b0; num_mb = '0;
      sif.s_valid = 1'b0; sif.s_last = 1'b0; sif.s_data = '0;
      for (int i = 0; i < 16; i++) script[i] = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lat_reset", lat_reset, 1);
      chk("rst_lat_en", lat_en, 0);
      chk("rst_s_ready", sif.s_ready, 0);
      chk("rst_mb_count", mb_count, 0);
      chk("rst_err_u", err_u, 0);
      chk("rst_err_t", err_t, 0);

      for (int i = 0; i < 16; i++) script[i] = '0;
      script[3] = 32'h1 << 6;
      run_case("one_mb", 4, 1, 0, 0);

      for (int i = 0; i < 16; i++) script[i] = '0;
      script[0] = (32'h1 << 20) | (32'h1 << 5);
      script[1] = 32'h1 << 28;
      run_case("three_mb", 2, 3, 0, 0);

      for (int i = 0; i < 16; i++) script[i] = '0;
      script[0] = (32'h1 << 20) | (32'h1 << 10) | (32'h1 << 2);
      run_case("clip_flush", 6, 2, 0, 1);

      for (int i = 0; i < 16; i++) script[i] = '0;
      script[3] = 32'h1 << 6;
      run_case("gaps", 4, 1, 3, 0);

      for (int i = 0; i < 16; i++) script[i] = '0;
      script[1] = 32'h1 << 9;
      run_case("underrun", 3, 2, 0, 0);

      for (int i = 0; i < 16; i++) script[i] = '0;
      run_case("timeout", 7, 1, 0, 0);

      for (int i = 0; i < 16; i++) script[i] = '0;
      script[0] = 32'h1;
      run_case("num_mb_zero", 2, 0, 0, 0);

      for (int i = 0; i < 16; i++) script[i] = '0;
      sb_en = 0;
      base = step_idx; st0 = n_steps; d0 = done_cnt;
      for (int i = 0; i < 3; i++) words[i] = $urandom;
      @(negedge clk);
      start = 1'b1; num_mb = 16'd5;
      @(negedge clk);
      start = 1'b0;
      send_words(3, 0, 1'b0, stalls);
      chk("rst_mid_stepped", n_steps > st0, 1);
      chk("rst_mid_busy_before", busy, 1);
      reset = 1'b1;
      @(negedge clk); #2;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_lat_reset", lat_reset, 1);
      chk("rst_mid_s_ready", sif.s_ready, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_mid_no_done", done_cnt - d0, 0);
      sb_en = 1;
      sbq.delete();

      script[3] = 32'h1 << 6;
      run_case("after_reset", 4, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
